scrambler_sequencer: RTL and testbench

Controller that drives the DATA-field scrambler (S(x)=x^7+x^4+1, all-ones seed, no clock enable) across one PLCP DATA field. It seeds the scrambler and emits the field in order: SERVICE (16 zero bits), PSDU bits, TAIL (6 bits), then PAD up to a multiple of N_DBPS. TAIL bits are forced to zero after scrambling. The scrambler shifts on every clock, so the block only streams continuously. It sits between the PSDU bit source and the convolutional encoder.

---
 rtl/scrambler_sequencer.sv | 173 +++++++++++++++++
 tb/tb_scrambler_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/scrambler_sequencer.sv
// Scrambler sequencer: drives the DATA-field scrambler (x^7+x^4+1, all-ones seed,
// free-running) across one PLCP DATA field.
// It emits SERVICE (16 zeros), then the PSDU, then TAIL (6 bits, forced to zero after
// scrambling), then PAD bits until the field fills a whole number of OFDM symbols.
//
// Ports:
//   Clock, Reset      - system clock, asynchronous active-high reset
//   Start             - frame request, sampled only in IDLE
//   Length, Dbps      - PSDU octet count and data bits per symbol, latched on Start
//   Data_Bit/Valid    - serialised PSDU bits from upstream
//   Data_Ready        - PSDU bit consumed this cycle (combinational, state == PSDU)
//   Scr_Reset         - registered scrambler reset (high whenever idle)
//   Scr_Input         - scrambler data input
//   Scr_Output        - scrambler data output (combinational)
//   Out_Bit/Out_Valid - DATA-field bit stream to the convolutional encoder
//   Busy, Done        - not idle / one-cycle end-of-frame pulse
//   Underrun          - one-cycle pulse when upstream starves the PSDU phase
module scrambler_sequencer #(
  parameter int unsigned LENGTH_WIDTH = 12,
  parameter int unsigned DBPS_WIDTH   = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [LENGTH_WIDTH-1:0] Length,
  input  logic [DBPS_WIDTH-1:0]   Dbps,
  input  logic                    Data_Bit,
  input  logic                    Data_Valid,
  output logic                    Data_Ready,
  output logic                    Scr_Reset,
  output logic                    Scr_Input,
  input  logic                    Scr_Output,
  output logic                    Out_Bit,
  output logic                    Out_Valid,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Underrun
);

  // Wide enough for Length*8 at maximum Length.
  localparam int unsigned CntWidth = LENGTH_WIDTH + 3;

  typedef enum logic [2:0] {
    StIdle,
    StService,
    StPsdu,
    StTail,
    StPad,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [LENGTH_WIDTH-1:0] length_q, length_d;
  logic [DBPS_WIDTH-1:0]   dbps_q, dbps_d;
  logic [CntWidth-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DBPS_WIDTH-1:0]   sym_cnt_q, sym_cnt_d;
  logic                    scr_reset_q, scr_reset_d;

  logic [CntWidth-1:0]   psdu_bits;
  logic                  psdu_last;
  logic [DBPS_WIDTH-1:0] sym_cnt_inc;
  logic                  pass_scr;  // Out_Bit follows the scrambler output this cycle

  assign psdu_bits   = {length_q, 3'b000};
  assign psdu_last   = (bit_cnt_q == psdu_bits - CntWidth'(1));
  // Symbol counter value after this cycle's increment, wrapping at Dbps-1.
  assign sym_cnt_inc = (sym_cnt_q == dbps_q - DBPS_WIDTH'(1)) ? '0 : sym_cnt_q + DBPS_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    dbps_d     = dbps_q;
    bit_cnt_d  = bit_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    Out_Valid  = 1'b0;
    pass_scr   = 1'b0;
    Data_Ready = 1'b0;
    Scr_Input  = 1'b0;
    Underrun   = 1'b0;
    Done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          length_d  = Length;
          dbps_d    = Dbps;
          bit_cnt_d = '0;
          sym_cnt_d = '0;
          state_d   = StService;
        end
      end
      StService: begin
        Out_Valid = 1'b1;
        pass_scr  = 1'b1;
        if (bit_cnt_q == CntWidth'(15)) begin
          bit_cnt_d = '0;
          state_d   = (length_q == '0) ? StTail : StPsdu;
        end else begin
          bit_cnt_d = bit_cnt_q + CntWidth'(1);
        end
      end
      StPsdu: begin
        Data_Ready = 1'b1;
        Scr_Input  = Data_Bit;
        if (Data_Valid) begin
          Out_Valid = 1'b1;
          pass_scr  = 1'b1;
          if (psdu_last) begin
            bit_cnt_d = '0;
            state_d   = StTail;
          end else begin
            bit_cnt_d = bit_cnt_q + CntWidth'(1);
          end
        end else begin
          // Starved mid-PSDU: the field cannot be resumed because the scrambler free-runs.
          Underrun = 1'b1;
          state_d  = StIdle;
        end
      end
      StTail: begin
        Out_Valid = 1'b1;
        if (bit_cnt_q == CntWidth'(5)) begin
          bit_cnt_d = '0;
          state_d   = (sym_cnt_inc == '0) ? StDone : StPad;
        end else begin
          bit_cnt_d = bit_cnt_q + CntWidth'(1);
        end
      end
      StPad: begin
        Out_Valid = 1'b1;
        pass_scr  = 1'b1;
        if (sym_cnt_inc == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        Done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (Out_Valid) begin
      sym_cnt_d = sym_cnt_inc;
    end
  end

  // Registered so the scrambler is released exactly on the first SERVICE cycle.
  assign scr_reset_d = (state_d == StIdle);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      length_q    <= '0;
      dbps_q      <= '0;
      bit_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      scr_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      dbps_q      <= dbps_d;
      bit_cnt_q   <= bit_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      scr_reset_q <= scr_reset_d;
    end
  end

  assign Scr_Reset = scr_reset_q;
  assign Out_Bit   = pass_scr & Scr_Output;
  assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_scrambler_sequencer.sv
// Directed bench for scrambler_sequencer with a behavioural x^7+x^4+1 scrambler attached.
module tb_scrambler_sequencer;
  localparam int unsigned LW = 12;
  localparam int unsigned DW = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [LW-1:0] Length;
  logic [DW-1:0] Dbps;
  logic          Data_Bit;
  logic          Data_Valid;
  logic          Data_Ready;
  logic          Scr_Reset;
  logic          Scr_Input;
  logic          Scr_Output;
  logic          Out_Bit;
  logic          Out_Valid;
  logic          Busy;
  logic          Done;
  logic          Underrun;

  int checks = 0;
  int errors = 0;
  bit seq [0:511];

  always #5 Clock = ~Clock;

  scrambler_sequencer #(
    .LENGTH_WIDTH(LW),
    .DBPS_WIDTH  (DW)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Length    (Length),
    .Dbps      (Dbps),
    .Data_Bit  (Data_Bit),
    .Data_Valid(Data_Valid),
    .Data_Ready(Data_Ready),
    .Scr_Reset (Scr_Reset),
    .Scr_Input (Scr_Input),
    .Scr_Output(Scr_Output),
    .Out_Bit   (Out_Bit),
    .Out_Valid (Out_Valid),
    .Busy      (Busy),
    .Done      (Done),
    .Underrun  (Underrun)
  );

  // Attached scrambler: synchronous reset to all ones, shifts every clock.
  logic [6:0] scr_q;
  always_ff @(posedge Clock) begin
    if (Scr_Reset) scr_q <= 7'h7f;
    else           scr_q <= {scr_q[5:0], scr_q[6] ^ scr_q[3]};
  end
  assign Scr_Output = Scr_Input ^ scr_q[6] ^ scr_q[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete frame with Data_Valid held high; optional ignored Start pulses in
  // SERVICE (cycle 5) and in the DONE cycle carrying a different Length/Dbps.
  task automatic run_frame(input int len, input int dbps, input logic [15:0] pat,
                           input bit pulse, input bit check16);
    int total, tail_lo, valid_cnt, ready_cnt, done_cnt, done_at, under_cnt;
    logic [15:0] first16;
    logic expb;
    total     = ((22 + 8 * len + dbps - 1) / dbps) * dbps;
    tail_lo   = 16 + 8 * len;
    valid_cnt = 0;
    ready_cnt = 0;
    done_cnt  = 0;
    under_cnt = 0;
    done_at   = -1;
    first16   = '0;
    @(posedge Clock); #1;
    Start = 1'b1; Length = LW'(len); Dbps = DW'(dbps); Data_Valid = 1'b1; Data_Bit = 1'b0;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int cyc = 0; cyc < total + 8; cyc++) begin
      Start = pulse && (cyc == 5 || cyc == total);
      if (pulse) begin
        Length = LW'(len + 3);
        Dbps   = DW'(200);
      end
      Data_Bit = (cyc >= 16 && cyc < tail_lo) ? pat[(cyc - 16) % 16] : 1'b0;
      @(negedge Clock);
      if (cyc == 0) check("scr_reset_released", 32'(Scr_Reset), 32'd0);
      if (Out_Valid) begin
        if (cyc >= tail_lo && cyc < tail_lo + 6) expb = 1'b0;
        else if (cyc >= 16 && cyc < tail_lo)     expb = seq[cyc] ^ pat[(cyc - 16) % 16];
        else                                     expb = seq[cyc];
        check("out_bit", 32'(Out_Bit), 32'(expb));
        if (cyc < 16) first16[15 - cyc] = Out_Bit;
        valid_cnt++;
      end
      if (Data_Ready) ready_cnt++;
      if (Underrun) under_cnt++;
      if (Done) begin
        done_cnt++;
        done_at = cyc;
        check("busy_in_done", 32'(Busy), 32'd1);
        check("scr_reset_in_done", 32'(Scr_Reset), 32'd0);
      end
      @(posedge Clock); #1;
      if (done_cnt > 0) break;
    end
    Start = 1'b0;
    @(negedge Clock);
    check("busy_after_done", 32'(Busy), 32'd0);
    check("scr_reset_after_done", 32'(Scr_Reset), 32'd1);
    check("done_width", 32'(Done), 32'd0);
    check("valid_count", 32'(valid_cnt), 32'(total));
    check("ready_count", 32'(ready_cnt), 32'(8 * len));
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_at), 32'(total));
    check("underrun_count", 32'(under_cnt), 32'd0);
    if (check16) check("service_bits", 32'(first16), 32'h0000_0EF2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] s;
    s = 7'h7f;
    for (int n = 0; n < 512; n++) begin
      seq[n] = s[6] ^ s[3];
      s = {s[5:0], seq[n]};
    end

    Reset = 1'b1; Start = 1'b0; Length = '0; Dbps = '0; Data_Bit = 1'b0; Data_Valid = 1'b0;
    repeat (2) @(negedge Clock);
    check("rst_scr_reset", 32'(Scr_Reset), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_data_ready", 32'(Data_Ready), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_underrun", 32'(Underrun), 32'd0);
    check("rst_out_bit", 32'(Out_Bit), 32'd0);
    check("rst_scr_input", 32'(Scr_Input), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    // Empty PSDU, two PAD bits.
    run_frame(0, 24, 16'h0000, 1'b0, 1'b1);
    // One octet of zeros, 18 PAD bits.
    run_frame(1, 24, 16'h0000, 1'b0, 1'b0);
    // Exact symbol fit: TAIL goes straight to DONE; non-zero data.
    run_frame(2, 38, 16'hA53C, 1'b0, 1'b0);

    // Underrun on the 3rd PSDU cycle.
    @(posedge Clock); #1;
    Start = 1'b1; Length = LW'(1); Dbps = DW'(24); Data_Valid = 1'b1; Data_Bit = 1'b0;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (18) @(posedge Clock);
    #1;
    Data_Valid = 1'b0;
    @(negedge Clock);
    check("ur_underrun", 32'(Underrun), 32'd1);
    check("ur_out_valid", 32'(Out_Valid), 32'd0);
    check("ur_data_ready", 32'(Data_Ready), 32'd1);
    check("ur_out_bit", 32'(Out_Bit), 32'd0);
    check("ur_done", 32'(Done), 32'd0);
    @(posedge Clock); #1;
    Data_Valid = 1'b1;
    @(negedge Clock);
    check("ur_busy_after", 32'(Busy), 32'd0);
    check("ur_scr_reset_after", 32'(Scr_Reset), 32'd1);
    check("ur_underrun_width", 32'(Underrun), 32'd0);
    run_frame(0, 24, 16'h0000, 1'b0, 1'b1);

    // Asynchronous reset in the 10th SERVICE cycle.
    @(posedge Clock); #1;
    Start = 1'b1; Length = LW'(1); Dbps = DW'(24);
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clock);
    #1;
    @(negedge Clock);
    check("ar_busy_before", 32'(Busy), 32'd1);
    check("ar_valid_before", 32'(Out_Valid), 32'd1);
    #1;
    Reset = 1'b1;
    #1;
    check("ar_busy", 32'(Busy), 32'd0);
    check("ar_out_valid", 32'(Out_Valid), 32'd0);
    check("ar_scr_reset", 32'(Scr_Reset), 32'd1);
    check("ar_done", 32'(Done), 32'd0);
    check("ar_underrun", 32'(Underrun), 32'd0);
    check("ar_out_bit", 32'(Out_Bit), 32'd0);
    repeat (2) begin
      @(negedge Clock);
      check("ar_done_held", 32'(Done), 32'd0);
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("ar_busy_released", 32'(Busy), 32'd0);
    check("ar_done_released", 32'(Done), 32'd0);

    // Start pulses while busy and in DONE are ignored.
    run_frame(0, 24, 16'h0000, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
